// File: rtl/lq_ooo_resp_if.sv
// Bus bundle for the out-of-order-response load queue: dispatch, memory
// request/response, writeback, flush and occupancy.
// When LQ_SUBWORD_EN is defined the dispatch side also carries access size
// and signedness.
interface lq_ooo_resp_if #(
  parameter int LQ_SIZE        = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ROB_W          = 4,
  parameter int PHYS_REG_IDX_W = 6
);
  localparam int LQ_IDX_W = $clog2(LQ_SIZE);
  localparam int TAG_W    = LQ_IDX_W + 1;

  logic                      enq_valid;
  logic                      enq_ready;
  logic [ROB_W-1:0]          enq_rob;
  logic [PHYS_REG_IDX_W-1:0] enq_phys_rd;
  logic [ADDR_W-1:0]         enq_addr;
`ifdef LQ_SUBWORD_EN
  logic [1:0]                enq_size;
  logic                      enq_signed;
`endif
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [ADDR_W-1:0]         mem_req_addr;
  logic [TAG_W-1:0]          mem_req_tag;
  logic                      mem_resp_valid;
  logic [TAG_W-1:0]          mem_resp_tag;
  logic [DATA_W-1:0]         mem_resp_data;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [ROB_W-1:0]          wb_rob;
  logic [PHYS_REG_IDX_W-1:0] wb_phys_rd;
  logic [DATA_W-1:0]         wb_data;
  logic                      flush;
  logic [LQ_IDX_W:0]         count;

  modport master (
    output enq_valid, enq_rob, enq_phys_rd, enq_addr,
`ifdef LQ_SUBWORD_EN
    output enq_size, enq_signed,
`endif
    output mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data,
    output wb_ready, flush,
    input  enq_ready, mem_req_valid, mem_req_addr, mem_req_tag,
    input  wb_valid, wb_rob, wb_phys_rd, wb_data, count
  );

  modport slave (
    input  enq_valid, enq_rob, enq_phys_rd, enq_addr,
`ifdef LQ_SUBWORD_EN
    input  enq_size, enq_signed,
`endif
    input  mem_req_ready, mem_resp_valid, mem_resp_tag, mem_resp_data,
    input  wb_ready, flush,
    output enq_ready, mem_req_valid, mem_req_addr, mem_req_tag,
    output wb_valid, wb_rob, wb_phys_rd, wb_data, count
  );
endinterface

// File: rtl/lq_ooo_resp.sv
// Load queue: in-order dispatch and issue, out-of-order response by tag,
// in-order writeback. Tags are {epoch, index}; a flush toggles the epoch so
// responses to flushed loads are recognised and dropped.
// Optional macro LQ_SUBWORD_EN: per-entry size/sign, response data is
// aligned, masked and extended before being latched.
module lq_ooo_resp #(
  parameter int LQ_SIZE        = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int ROB_W          = 4,
  parameter int PHYS_REG_IDX_W = 6
) (
  input logic          clk,
  input logic          rst,
  lq_ooo_resp_if.slave bus
);
  localparam int LQ_IDX_W = $clog2(LQ_SIZE);
  localparam int CNT_W    = LQ_IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LQ_SIZE);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_WAIT = 2'd1,
    ST_INFL = 2'd2,
    ST_DONE = 2'd3
  } ent_st_e;

  ent_st_e                   state_q [LQ_SIZE];
  ent_st_e                   state_d [LQ_SIZE];
  logic [ADDR_W-1:0]         addr_q  [LQ_SIZE];
  logic [ROB_W-1:0]          rob_q   [LQ_SIZE];
  logic [PHYS_REG_IDX_W-1:0] rd_q    [LQ_SIZE];
  logic [DATA_W-1:0]         data_q  [LQ_SIZE];
  logic [LQ_IDX_W-1:0]       head_q, head_d, tail_q, tail_d, iss_q, iss_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      epoch_q, epoch_d;

  logic                      enq_fire_s, req_fire_s, wb_fire_s, resp_hit_s;
  logic [LQ_IDX_W-1:0]       resp_idx_s;
  logic                      resp_ep_s;
  logic [DATA_W-1:0]         resp_data_s;

`ifdef LQ_SUBWORD_EN
  localparam int OFF_W = $clog2(DATA_W / 8);
  logic [1:0]                size_q  [LQ_SIZE];
  logic                      sgn_q   [LQ_SIZE];

  // Align the addressed bytes to bit 0, keep 8<<size bits, extend the rest.
  function automatic logic [DATA_W-1:0] fmt_subword(
    input logic [DATA_W-1:0] raw,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              sgn
  );
    logic [DATA_W-1:0] shifted;
    logic              fill;
    int                nbits;
    shifted = raw >> {off, 3'b000};
    nbits   = int'(32'd8 << size);
    if (nbits > DATA_W) nbits = DATA_W;
    else                nbits = nbits;
    fill = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == nbits - 1) fill = sgn & shifted[i];
      else                fill = fill;
    end
    for (int i = 0; i < DATA_W; i++) begin
      fmt_subword[i] = (i < nbits) ? shifted[i] : fill;
    end
  endfunction

  assign resp_data_s = fmt_subword(bus.mem_resp_data, addr_q[resp_idx_s][OFF_W-1:0],
                                   size_q[resp_idx_s], sgn_q[resp_idx_s]);
`else
  assign resp_data_s = bus.mem_resp_data;
`endif

  assign resp_idx_s = bus.mem_resp_tag[LQ_IDX_W-1:0];
  assign resp_ep_s  = bus.mem_resp_tag[LQ_IDX_W];

  assign bus.enq_ready     = (count_q < CNT_FULL);
  assign bus.mem_req_valid = (state_q[iss_q] == ST_WAIT);
  assign bus.mem_req_addr  = addr_q[iss_q];
  assign bus.mem_req_tag   = {epoch_q, iss_q};
  assign bus.wb_valid      = (state_q[head_q] == ST_DONE);
  assign bus.wb_rob        = rob_q[head_q];
  assign bus.wb_phys_rd    = rd_q[head_q];
  assign bus.wb_data       = data_q[head_q];
  assign bus.count         = count_q;

  // Handshake qualification; a flush cancels every handshake in its cycle.
  always_comb begin
    enq_fire_s = bus.enq_valid && bus.enq_ready && !bus.flush;
    req_fire_s = bus.mem_req_valid && bus.mem_req_ready && !bus.flush;
    wb_fire_s  = bus.wb_valid && bus.wb_ready && !bus.flush;
    resp_hit_s = bus.mem_resp_valid && (resp_ep_s == epoch_q) &&
                 (state_q[resp_idx_s] == ST_INFL);
  end

  // Next state of entry states, pointers, occupancy and epoch.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    iss_d   = iss_q;
    count_d = count_q;
    epoch_d = epoch_q;
    if (bus.flush) begin
      for (int i = 0; i < LQ_SIZE; i++) state_d[i] = ST_FREE;
      head_d  = '0;
      tail_d  = '0;
      iss_d   = '0;
      count_d = '0;
      epoch_d = ~epoch_q;
    end else begin
      // The four events touch disjoint slots (INFL, WAIT, DONE, FREE).
      if (resp_hit_s) state_d[resp_idx_s] = ST_DONE;
      else            state_d[resp_idx_s] = state_d[resp_idx_s];
      if (req_fire_s) begin
        state_d[iss_q] = ST_INFL;
        iss_d          = iss_q + 1'b1;
      end else begin
        iss_d = iss_q;
      end
      if (wb_fire_s) begin
        state_d[head_q] = ST_FREE;
        head_d          = head_q + 1'b1;
      end else begin
        head_d = head_q;
      end
      if (enq_fire_s) begin
        state_d[tail_q] = ST_WAIT;
        tail_d          = tail_q + 1'b1;
      end else begin
        tail_d = tail_q;
      end
      case ({enq_fire_s, wb_fire_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LQ_SIZE; i++) state_q[i] <= ST_FREE;
      head_q  <= '0;
      tail_q  <= '0;
      iss_q   <= '0;
      count_q <= '0;
      epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      iss_q   <= iss_d;
      count_q <= count_d;
      epoch_q <= epoch_d;
    end
  end

  // Per-entry payload; validity is carried by the state, so no reset needed.
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      addr_q[tail_q] <= bus.enq_addr;
      rob_q[tail_q]  <= bus.enq_rob;
      rd_q[tail_q]   <= bus.enq_phys_rd;
`ifdef LQ_SUBWORD_EN
      size_q[tail_q] <= bus.enq_size;
      sgn_q[tail_q]  <= bus.enq_signed;
`endif
    end
    if (resp_hit_s) data_q[resp_idx_s] <= resp_data_s;
  end
endmodule

// File: tb/tb_lq_ooo_resp.sv
// Self-checking bench for lq_ooo_resp: directed scenarios followed by a
// randomized phase with an out-of-order memory responder and a scoreboard.
module tb_lq_ooo_resp;
  localparam int LQ_SIZE = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int PRW     = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lq_ooo_resp_if #(.LQ_SIZE(LQ_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                   .ROB_W(ROB_W), .PHYS_REG_IDX_W(PRW)) bus();
  lq_ooo_resp #(.LQ_SIZE(LQ_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                .ROB_W(ROB_W), .PHYS_REG_IDX_W(PRW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory contents as a function of address (one directed exception).
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a[31:16] == 16'hD1D1) return 32'h8000_0000;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

`ifdef LQ_SUBWORD_EN
  // Reference load extraction: byte offset, size mask, optional sign fill.
  function automatic logic [31:0] sub_model(input logic [31:0] raw, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic sg);
    longint unsigned v, m;
    int nb;
    nb = 1 << sz;
    v  = 64'(raw) >> (8 * int'(addr[1:0]));
    m  = (64'd1 << (8 * nb)) - 64'd1;
    v  = v & m;
    if (sg && v[8*nb-1]) v = v | ~m;
    return v[31:0];
  endfunction
`endif

  // ---------------- scoreboard ----------------
  typedef struct { logic [ROB_W-1:0] rob; logic [PRW-1:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [31:0] addr; logic [3:0] tag; } rq_t;
  wb_t  exp_q[$];
  rq_t  req_q[$];
  logic m_ep;
  int   m_alloc;
  logic wb_hold, rq_hold;
  logic [63:0] wb_saved, rq_saved;

  always @(negedge clk) begin
    wb_t e;
    rq_t r;
    if (rst) begin
      exp_q.delete(); req_q.delete();
      m_ep = 1'b0; m_alloc = 0; wb_hold = 1'b0; rq_hold = 1'b0;
    end else begin
      check("count", 64'(bus.count), 64'(exp_q.size()));
      check("enq_ready", 64'(bus.enq_ready), 64'(exp_q.size() < LQ_SIZE));
      if (wb_hold) begin
        check("wb_hold_valid", 64'(bus.wb_valid), 64'd1);
        check("wb_hold_fields", {22'd0, bus.wb_rob, bus.wb_phys_rd, bus.wb_data}, wb_saved);
      end
      if (rq_hold) begin
        check("req_hold_valid", 64'(bus.mem_req_valid), 64'd1);
        check("req_hold_fields", {28'd0, bus.mem_req_tag, bus.mem_req_addr}, rq_saved);
      end
      if (bus.flush) begin
        exp_q.delete(); req_q.delete();
        m_ep = ~m_ep; m_alloc = 0;
      end else begin
        if (bus.wb_valid && bus.wb_ready) begin
          if (exp_q.size() == 0) check("wb_spurious", 64'(bus.wb_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("wb_rob", 64'(bus.wb_rob), 64'(e.rob));
            check("wb_phys_rd", 64'(bus.wb_phys_rd), 64'(e.rd));
            check("wb_data", 64'(bus.wb_data), 64'(e.data));
          end
        end
        if (bus.mem_req_valid && bus.mem_req_ready) begin
          if (req_q.size() == 0) check("req_spurious", 64'(bus.mem_req_valid), 64'd0);
          else begin
            r = req_q.pop_front();
            check("req_addr", 64'(bus.mem_req_addr), 64'(r.addr));
            check("req_tag", 64'(bus.mem_req_tag), 64'(r.tag));
          end
        end
        if (bus.enq_valid && bus.enq_ready) begin
          e.rob = bus.enq_rob;
          e.rd  = bus.enq_phys_rd;
`ifdef LQ_SUBWORD_EN
          e.data = sub_model(mem_val(bus.enq_addr), bus.enq_addr, bus.enq_size, bus.enq_signed);
`else
          e.data = mem_val(bus.enq_addr);
`endif
          exp_q.push_back(e);
          r.addr = bus.enq_addr;
          r.tag  = {m_ep, 3'(m_alloc)};
          req_q.push_back(r);
          m_alloc = (m_alloc + 1) % LQ_SIZE;
        end
      end
      wb_hold  = bus.wb_valid && !bus.wb_ready && !bus.flush;
      wb_saved = {22'd0, bus.wb_rob, bus.wb_phys_rd, bus.wb_data};
      rq_hold  = bus.mem_req_valid && !bus.mem_req_ready && !bus.flush;
      rq_saved = {28'd0, bus.mem_req_tag, bus.mem_req_addr};
    end
  end

  // ---------------- memory responder ----------------
  typedef struct { logic [3:0] tag; logic [31:0] addr; bit stale; } pend_t;
  pend_t       pend[$];
  int          stale_cnt = 0;
  logic        auto_mode = 1'b0;
  logic        a_v = 1'b0, m_v = 1'b0;
  logic [3:0]  a_tag = 4'd0, m_tag = 4'd0;
  logic [31:0] a_data = 32'd0, m_data = 32'd0;

  assign bus.mem_resp_valid = auto_mode ? a_v : m_v;
  assign bus.mem_resp_tag   = auto_mode ? a_tag : m_tag;
  assign bus.mem_resp_data  = auto_mode ? a_data : m_data;

  // Captures accepted requests; answers them in random order, stale ones first.
  always begin
    int k;
    @(negedge clk);
    if (rst) begin
      pend.delete(); stale_cnt = 0;
    end else if (bus.flush) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      stale_cnt = pend.size();
    end else if (auto_mode && bus.mem_req_valid && bus.mem_req_ready) begin
      pend.push_back('{bus.mem_req_tag, bus.mem_req_addr, 1'b0});
    end
    @(posedge clk);
    #1;
    a_v = 1'b0;
    if (auto_mode && pend.size() > 0 && $urandom_range(0, 2) != 0) begin
      if (stale_cnt > 0) begin
        k = 0;
        stale_cnt--;
      end else begin
        k = $urandom_range(0, pend.size() - 1);
      end
      a_v    = 1'b1;
      a_tag  = pend[k].tag;
      a_data = pend[k].stale ? ~mem_val(pend[k].addr) : mem_val(pend[k].addr);
      pend.delete(k);
    end
  end

  // ---------------- stimulus ----------------
  task automatic enq(input logic [3:0] rob, input logic [5:0] rd, input logic [31:0] addr);
    bus.enq_valid   = 1'b1;
    bus.enq_rob     = rob;
    bus.enq_phys_rd = rd;
    bus.enq_addr    = addr;
    tick;
    bus.enq_valid = 1'b0;
  endtask

  task automatic resp(input logic [3:0] tag, input logic [31:0] data);
    m_v = 1'b1; m_tag = tag; m_data = data;
    tick;
    m_v = 1'b0;
  endtask

  task automatic do_flush;
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    check("flush_count", 64'(bus.count), 64'd0);
  endtask

  initial begin
    int waited;
    bus.enq_valid = 1'b0; bus.enq_rob = '0; bus.enq_phys_rd = '0; bus.enq_addr = '0;
`ifdef LQ_SUBWORD_EN
    bus.enq_size = 2'd2; bus.enq_signed = 1'b0;
`endif
    bus.mem_req_ready = 1'b0; bus.wb_ready = 1'b0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);

    // Out-of-order responses, in-order writeback.
    bus.mem_req_ready = 1'b1; bus.wb_ready = 1'b1;
    enq(4'd1, 6'd1, 32'h100); enq(4'd2, 6'd2, 32'h104); enq(4'd3, 6'd3, 32'h108);
    repeat (3) tick;
    resp(4'h2, mem_val(32'h108));
    check("t1_no_early_wb", 64'(bus.wb_valid), 64'd0);
    resp(4'h0, mem_val(32'h100));
    check("t1_wb_latency", 64'(bus.wb_valid), 64'd1);
    check("t1_wb_rob1", 64'(bus.wb_rob), 64'd1);
    resp(4'h1, mem_val(32'h104));
    repeat (3) tick;
    check("t1_drained", 64'(bus.count), 64'd0);
    do_flush;                                   // epoch 1

    // Fill, full backpressure, request stall, writeback stall.
    bus.mem_req_ready = 1'b0; bus.wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) enq(4'(i + 4), 6'(i), 32'h200 + 32'(4 * i));
    check("t2_full_count", 64'(bus.count), 64'd8);
    check("t2_full_ready", 64'(bus.enq_ready), 64'd0);
    enq(4'd15, 6'd15, 32'h300);
    check("t2_ninth_dropped", 64'(bus.count), 64'd8);
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_valid", 64'(bus.mem_req_valid), 64'd1);
      check("t2_stall_addr", 64'(bus.mem_req_addr), 64'h200);
      check("t2_stall_tag", 64'(bus.mem_req_tag), 64'h8);
      tick;
    end
    bus.mem_req_ready = 1'b1;
    repeat (8) tick;
    check("t2_all_issued", 64'(bus.mem_req_valid), 64'd0);
    resp(4'h8, mem_val(32'h200));
    for (int i = 0; i < 4; i++) begin
      check("t2_wb_stall_valid", 64'(bus.wb_valid), 64'd1);
      check("t2_wb_stall_rob", 64'(bus.wb_rob), 64'd4);
      tick;
    end
    bus.wb_ready = 1'b1;
    tick;
    bus.wb_ready = 1'b0;
    check("t2_after_wb_count", 64'(bus.count), 64'd7);
    check("t2_after_wb_ready", 64'(bus.enq_ready), 64'd1);
    resp(4'h9, mem_val(32'h204));
    bus.wb_ready = 1'b1;
    enq(4'd14, 6'd14, 32'h240);
    bus.wb_ready = 1'b0;
    check("t2_enq_wb_same", 64'(bus.count), 64'd7);
    do_flush;                                   // epoch 0

    // Flush with loads in flight; stale response must be dropped.
    bus.mem_req_ready = 1'b1; bus.wb_ready = 1'b1;
    enq(4'd1, 6'd10, 32'h400); enq(4'd2, 6'd11, 32'h404);
    repeat (2) tick;
    do_flush;                                   // epoch 1
    enq(4'd3, 6'd12, 32'h408);
    tick;
    resp(4'h0, 32'hDEAD_BEEF);
    check("t3_stale_dropped", 64'(bus.wb_valid), 64'd0);
    resp(4'h8, mem_val(32'h408));
    check("t3_new_valid", 64'(bus.wb_valid), 64'd1);
    check("t3_new_data", 64'(bus.wb_data), 64'(mem_val(32'h408)));
    tick;
`ifdef LQ_SUBWORD_EN
    bus.enq_size = 2'd0; bus.enq_signed = 1'b1;
    enq(4'd7, 6'd7, 32'hD1D1_0103);
    tick;
    resp(4'h9, 32'h8000_0000);
    check("sub_signed_byte", 64'(bus.wb_data), 64'hFFFF_FF80);
    tick;
    bus.enq_signed = 1'b0;
    enq(4'd8, 6'd8, 32'hD1D1_0103);
    tick;
    resp(4'hA, 32'h8000_0000);
    check("sub_unsigned_byte", 64'(bus.wb_data), 64'h0000_0080);
    tick;
`endif

    // Randomized traffic with out-of-order responses and occasional flushes.
    auto_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      bus.enq_valid     = ($urandom_range(0, 9) < 6);
      bus.enq_rob       = 4'($urandom);
      bus.enq_phys_rd   = 6'($urandom);
      bus.enq_addr      = $urandom;
`ifdef LQ_SUBWORD_EN
      bus.enq_size      = 2'($urandom_range(0, 2));
      bus.enq_signed    = 1'($urandom);
`endif
      bus.mem_req_ready = ($urandom_range(0, 9) < 7);
      bus.wb_ready      = ($urandom_range(0, 9) < 7);
      bus.flush         = ($urandom_range(0, 299) == 0) && (stale_cnt == 0);
      tick;
    end

    // Drain everything still outstanding.
    bus.enq_valid = 1'b0; bus.flush = 1'b0;
    bus.mem_req_ready = 1'b1; bus.wb_ready = 1'b1;
    waited = 0;
    while ((bus.count != 0 || pend.size() != 0) && waited < 1000) begin
      tick;
      waited++;
    end
    check("drain_timeout", 64'(waited < 1000), 64'd1);
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lq_ooo_resp.md
Name: lq_ooo_resp

Overview:
- Parametrised successor to the in-order load queue.
- Buffers issued loads in program order and presents memory requests with a valid/ready handshake.
- Accepts memory responses out of order by tag and writes completed loads back in program order.
- Supports a full-queue flush for mispredict/exception recovery; stale responses are discarded via an epoch bit in the tag.

Parameters:
- LQ_SIZE, 8, number of entries; power of two, >=2.
- ADDR_W, 32, load address width.
- DATA_W, 32, memory/register data width; multiple of 8.
- ROB_W, 4, ROB index width.
- PHYS_REG_IDX_W, 6, physical destination register index width.
- LQ_IDX_W (local), $clog2(LQ_SIZE).
- TAG_W (local), LQ_IDX_W+1: {epoch, index}.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enq_valid  in  1  load dispatch request.
- enq_ready  out  1  queue can accept; equals count < LQ_SIZE.
- enq_rob  in  ROB_W  ROB tag of load.
- enq_phys_rd  in  PHYS_REG_IDX_W  destination physical register.
- enq_addr  in  ADDR_W  effective address.
- mem_req_valid  out  1  request to memory pending.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_tag  out  TAG_W  {epoch, entry index}.
- mem_resp_valid  in  1  memory response.
- mem_resp_tag  in  TAG_W  tag of response.
- mem_resp_data  in  DATA_W  response data.
- wb_valid  out  1  oldest load complete.
- wb_ready  in  1  writeback port accepts.
- wb_rob  out  ROB_W  ROB tag of completing load.
- wb_phys_rd  out  PHYS_REG_IDX_W  destination register.
- wb_data  out  DATA_W  load result.
- flush  in  1  discard all entries.
- count  out  LQ_IDX_W+1  occupied entries.

Behaviour:
- Entry state per slot: FREE -> WAIT (enq) -> INFL (request accepted) -> DONE (response matched) -> FREE (writeback fires).
- Pointers: head (oldest), tail (next alloc), iss (next to issue). All are LQ_IDX_W bits and wrap from LQ_SIZE-1 to 0. count is a separate counter.
- Reset:
  - All entries FREE; head = tail = iss = 0; epoch = 0; count = 0.
  - Outputs: enq_ready = 1, mem_req_valid = 0, wb_valid = 0. Data outputs are don't-care.
- Enqueue: on enq_valid && enq_ready, write the tail slot (state WAIT), advance tail, count+1.
- Issue:
  - mem_req_valid = (state[iss] == WAIT).
  - mem_req_addr = addr[iss]; mem_req_tag = {epoch, iss}.
  - On mem_req_valid && mem_req_ready: state[iss] -> INFL and iss advances.
  - Requests issue strictly in program order. An enqueue into an empty queue is visible at issue the next cycle.
- Response:
  - On mem_resp_valid, if tag epoch == epoch and state[tag index] == INFL: latch data and set state DONE.
  - Otherwise drop silently: no state change. This covers stale epochs and responses to non-INFL entries.
- Writeback:
  - wb_valid = (state[head] == DONE); wb_rob, wb_phys_rd and wb_data come from head.
  - On wb_valid && wb_ready: head -> FREE, head advances, count-1.
  - Data is registered, so minimum latency is response at cycle N -> wb_valid at cycle N+1.
  - wb_valid stays asserted with stable outputs until accepted.
- Simultaneous events:
  - Enq and wb in the same cycle: count unchanged.
  - When full, enq_ready = 0 even if wb fires that cycle (no bypass).
  - Response and issue to different slots in the same cycle are both applied.
- Flush (priority over all other updates in that cycle):
  - All entries FREE; head = tail = iss = 0; count = 0; epoch toggles.
  - Enq, wb and req handshakes in that cycle are ignored.
  - Responses arriving during or after the flush that carry the old epoch are dropped.
  - A response with the old epoch that arrives after a second flush aliases the current epoch. Memory guarantees responses return within one flush interval.
- Reset mid-operation: same as reset values. Epoch returns to 0. Memory is reset concurrently.

Optional Feature:
- Macro: LQ_SUBWORD_EN.
- When defined:
  - Adds inputs enq_size (2 bits: 0 = byte, 1 = half, 2 = word, 3 = dword when DATA_W >= 64) and enq_signed (1 bit). Both are stored per entry.
  - On response, data is shifted right by addr[$clog2(DATA_W/8)-1:0] * 8, masked to the size, then sign- or zero-extended to DATA_W before latching.
- When undefined: these ports are absent and wb_data = raw mem_resp_data.

Test Plan:
- Enqueue rob 1, 2, 3 (addr 0x100, 0x104, 0x108), mem_req_ready = 1 -> tags 0, 1, 2 issued in order. Responses in order tag 2, 0, 1 with data 0xC, 0xA, 0xB -> wb order rob 1 = 0xA, rob 2 = 0xB, rob 3 = 0xC. rob 1 writes back the cycle after tag 0's response.
- Fill 8 entries with wb_ready = 0 -> enq_ready = 0 and count = 8. Ninth enq_valid is not accepted. One wb fires -> enq_ready = 1 next cycle. 20 further enq/wb cycles wrap pointers with no loss.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid, addr and tag stay stable; no entry leaves WAIT.
- Issue tags 0 and 1, then flush -> count = 0 and epoch = 1. A late response with tag {0,0} is dropped. A new load issues with tag {1,0}, its response arrives, and wb returns the new data only.
- wb_ready = 0 with head DONE for 4 cycles -> wb_valid and data stable. Enqueue and writeback in the same cycle -> count unchanged.
- With LQ_SUBWORD_EN: addr 0x103, byte, signed, data 0x80_00_00_00 -> wb_data 0xFFFFFF80. Same load with unsigned -> 0x00000080.
